// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_rd_packer                                               |
// | Description : Drains a FWFT FIFO read port and packs PACK entries into one |
// |               wide word behind a registered valid/ready output; flush      |
// |               emits a partial word together with its lane count.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fifo_rd_packer #(
    parameter int DATALEN = 8,
    parameter int PACK    = 4,
    parameter int CNTW    = 3
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     fifo_empty_i,
    input  logic [DATALEN-1:0]       fifo_rdata_i,
    output logic                     fifo_rinc_o,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PACK*DATALEN-1:0]  out_data_o,
    output logic [CNTW-1:0]          out_cnt_o
);

    localparam int              c_W        = PACK * DATALEN;
    localparam logic [CNTW-1:0] c_PACK_CNT = CNTW'(PACK);

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t      r_state;
    out_state_t      w_state_nxt;

    logic [c_W-1:0]  r_asm_data;
    logic [c_W-1:0]  w_asm_data_nxt;
    logic [c_W-1:0]  w_asm_masked;
    logic [CNTW-1:0] r_asm_cnt;
    logic [CNTW-1:0] w_asm_cnt_nxt;
    logic [c_W-1:0]  r_out_data;
    logic [CNTW-1:0] r_out_cnt;
    logic            r_flush_pend;
    logic            w_flush_pend_nxt;
    logic            w_out_free;
    logic            w_asm_full;
    logic            w_xfer;
    logic            w_pop;

    assign w_out_free = (r_state == OUT_EMPTY) | out_ready_i;
    assign w_asm_full = (r_asm_cnt == c_PACK_CNT);
    assign w_xfer     = w_out_free & (w_asm_full | (r_flush_pend & (r_asm_cnt != '0)));
    // rrst_n gating keeps the pop strobe quiet for the whole reset assertion.
    assign w_pop      = rrst_n & ~fifo_empty_i & ~r_flush_pend & (~w_asm_full | w_xfer);

    assign w_flush_pend_nxt = flush_i | (r_flush_pend & ~w_xfer & (r_asm_cnt != '0));

    generate
        for (genvar g = 0; g < PACK; g++) begin : g_mask
            assign w_asm_masked[g*DATALEN +: DATALEN] =
                (CNTW'(g) < r_asm_cnt) ? r_asm_data[g*DATALEN +: DATALEN] : '0;
        end
    endgenerate

    always_comb begin
        w_asm_data_nxt = r_asm_data;
        w_asm_cnt_nxt  = r_asm_cnt;
        if (w_xfer) begin
            w_asm_data_nxt = '0;
            w_asm_cnt_nxt  = '0;
            if (w_pop) begin
                w_asm_data_nxt[DATALEN-1:0] = fifo_rdata_i;
                w_asm_cnt_nxt               = CNTW'(1);
            end
        end else if (w_pop) begin
            for (int i = 0; i < PACK; i++) begin
                if (r_asm_cnt == CNTW'(i)) begin
                    w_asm_data_nxt[i*DATALEN +: DATALEN] = fifo_rdata_i;
                end
            end
            w_asm_cnt_nxt = r_asm_cnt + CNTW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = OUT_FULL;
        end else if ((r_state == OUT_FULL) && out_ready_i) begin
            w_state_nxt = OUT_EMPTY;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_asm_data   <= '0;
            r_asm_cnt    <= '0;
            r_flush_pend <= 1'b0;
            r_out_data   <= '0;
            r_out_cnt    <= '0;
        end else begin
            r_asm_data   <= w_asm_data_nxt;
            r_asm_cnt    <= w_asm_cnt_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            if (w_xfer) begin
                r_out_data <= w_asm_masked;
                r_out_cnt  <= r_asm_cnt;
            end
        end
    end

    assign fifo_rinc_o = w_pop;
    assign out_valid_o = (r_state == OUT_FULL);
    assign out_data_o  = r_out_data;
    assign out_cnt_o   = r_out_cnt;

endmodule
`default_nettype wire
